// File: rtl/lut_cfg_pkg.sv
// rtl/lut_cfg_pkg.sv - shared state encoding and sizing helpers for the LUT config loader
package lut_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    function automatic int beats_f(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-beat table still needs a one-bit counter so the port widths stay legal.
    function automatic int cnt_w_f(input int width, input int chunk);
        int beats;
        beats = width / chunk;
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/lut_cfg_shadow.sv
// rtl/lut_cfg_shadow.sv - CHUNK-wide right-shift register holding the table under assembly
module lut_cfg_shadow #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic [CHUNK-1:0] shift_in,
    output logic [WIDTH-1:0] shadow
);

    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] shadow_d;

    generate
        if (WIDTH == CHUNK) begin : g_single
            always_comb begin
                shadow_d = shadow_q;
                if (shift_en) begin
                    shadow_d = shift_in;
                end
            end
        end else begin : g_multi
            // New chunks enter at the top so the first chunk ends up in the low bits.
            always_comb begin
                shadow_d = shadow_q;
                if (shift_en) begin
                    shadow_d = {shift_in, shadow_q[WIDTH-1:CHUNK]};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign shadow = shadow_q;

endmodule

// File: rtl/lut_config_loader.sv
// rtl/lut_config_loader.sv - streams a LUT truth table into a shadow register and commits it atomically
module lut_config_loader
    import lut_cfg_pkg::*;
#(
    parameter int INPUTS = 4,
    parameter int WIDTH  = 1 << INPUTS,
    parameter int CHUNK  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic             cfg_valid,
    input  logic [CHUNK-1:0] cfg_data,
    output logic             cfg_ready,
    output logic             busy,
    output logic             cfg_done,
    output logic             loaded,
    output logic [WIDTH-1:0] values
);

    localparam int BEATS = beats_f(WIDTH, CHUNK);
    localparam int CNT_W = cnt_w_f(WIDTH, CHUNK);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("lut_config_loader: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] values_q, values_d;
    logic             loaded_q, loaded_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] shadow;
    logic             accept;
    logic             shift_en;

    // Ready is decoded from the state flop only, so it never depends on an input this cycle.
    assign cfg_ready = (state_q == SHIFT);
    assign accept    = cfg_valid & cfg_ready;
    assign shift_en  = accept & ~cfg_abort;

    lut_cfg_shadow #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) u_shadow (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .shift_in (cfg_data),
        .shadow   (shadow)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        values_d = values_q;
        loaded_d = loaded_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // Abort wins over a beat landing in the same cycle; that beat is dropped.
                if (cfg_abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (accept) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = COMMIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            COMMIT: begin
                values_d = shadow;
                loaded_d = 1'b1;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            values_q <= '0;
            loaded_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            values_q <= values_d;
            loaded_q <= loaded_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign cfg_done = done_q;
    assign loaded   = loaded_q;
    assign values   = values_q;

endmodule

// File: doc/lut_config_loader.md
Name: lut_config_loader

Overview:
- Configuration-load stage directly upstream of the LUT predecoder mux.
- Receives LUT truth-table bits as a chunked stream under a valid/ready handshake and assembles them in a shadow register.
- Commits the full word atomically onto the `values` bus that drives the mux, so the mux never sees a partially loaded table.
- Reports completion with a one-cycle done pulse.

Parameters:
- INPUTS, 4, LUT select width; must match the downstream predecoder.
- WIDTH, 1<<INPUTS, truth-table bits; equals the downstream `values` width.
- CHUNK, 1, bits per stream beat; WIDTH % CHUNK == 0 is required (elaboration error otherwise).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_start  in  1  begin a load; honoured only in IDLE.
- cfg_abort  in  1  cancel an in-progress load.
- cfg_valid  in  1  cfg_data valid.
- cfg_data  in  CHUNK  next chunk, LSB-first order.
- cfg_ready  out  1  loader accepts a beat.
- busy  out  1  state != IDLE.
- cfg_done  out  1  one-cycle pulse: new table committed.
- loaded  out  1  values holds a committed table since reset.
- values  out  WIDTH  active truth table to the predecoder.

Behaviour:
- Reset (async assert, sync release): state=IDLE, beat counter=0, shadow=0, values=0, loaded=0, cfg_done=0. Outputs go to these values immediately on assert.
- BEATS = WIDTH/CHUNK. Counter width = max(1, clog2(BEATS)).
- Beat accepted = cfg_valid & cfg_ready at a rising edge.
- On accept: shadow <= {cfg_data, shadow[WIDTH-1:CHUNK]}. After BEATS accepts, the first chunk sits in shadow[CHUNK-1:0].
- cfg_ready = (state==SHIFT). It is a registered decode only, with no combinational path from any input.
- FSM:
  - IDLE: cfg_start -> SHIFT, counter=0. cfg_abort has no effect in IDLE.
  - SHIFT: on an accepted beat, counter++. If counter==BEATS-1 -> COMMIT. Gaps in cfg_valid stall indefinitely with no timeout.
  - SHIFT + cfg_abort: -> IDLE, counter=0. values and loaded are unchanged. Abort takes priority over a beat accepted in the same cycle; that beat is discarded.
  - COMMIT (exactly one cycle): values <= shadow, loaded <= 1, cfg_done <= 1 (registered, so high in the cycle after COMMIT) -> IDLE. cfg_start and cfg_abort are ignored in COMMIT.
- Latency: the edge that accepts the last beat enters COMMIT. The next edge updates values and raises cfg_done. New values are visible 2 edges after the last handshake.
- cfg_done coincides with the first cycle values shows the new table. It is deasserted the following cycle.
- cfg_start during SHIFT or COMMIT is ignored; it is not queued.
- A new load may begin from IDLE in the cycle cfg_done is high.
- values holds its last committed table throughout any subsequent load or abort. It changes only at COMMIT or reset.
- Reset mid-load: all state is cleared, including values=0 and loaded=0. No cfg_done is produced.
- cfg_data is don't-care when cfg_valid=0 or cfg_ready=0.

Decomposition:
- Package lut_cfg_pkg contains:
  - state enum {IDLE, SHIFT, COMMIT}, 2 bits;
  - beats/counter-width helper functions taking WIDTH and CHUNK.
- Sub-module lut_cfg_shadow: WIDTH-bit, CHUNK-wide right-shift register with a shift enable. Holds shadow data only; no control logic.
- Top level holds the FSM, counter, the values/loaded/cfg_done registers, and the parameter check.

Test Plan:
- WIDTH=16, CHUNK=1: start, then 16 back-to-back beats of 16'hA5C3 LSB-first -> values==16'hA5C3 and cfg_done high for exactly 1 cycle, 2 edges after the last handshake; loaded=1; busy low the next cycle.
- CHUNK=4: beats 4'h3, 4'hC, 4'h5, 4'hA with random 0-3 cycle valid gaps -> values==16'hA5C3; cfg_ready high throughout SHIFT; no extra beats consumed.
- Table 16'hA5C3 loaded, then start and 7 beats of 1s, then abort asserted together with beat 8 -> values stays 16'hA5C3, no cfg_done, state IDLE. A following full load of 16'h0FF0 yields 16'h0FF0.
- rst_n pulled low asynchronously mid-load (between edges) after a prior commit -> values=0, loaded=0, cfg_ready=0 immediately. A subsequent full load succeeds.
- cfg_start held high during SHIFT and COMMIT -> ignored, counter not reset. Start asserted in the cfg_done cycle begins a new load correctly.
- Drive all 16 indices of s into the downstream predecoder after loading 16'hA5C3 -> z equals bit s of 16'hA5C3 for each index.
